seg_grade_decoder: RTL

- Receive side of the grade-letter 7-segment path: monitors an 8-bit segment bus (the letter patterns the grade encoder drives onto SEG) and decodes it back into a letter code.
- Accepts a pattern only after it has been stable for a programmable number of cycles.
- Emits a one-cycle event per accepted letter and keeps saturating per-letter tallies plus an error tally, for display on the LCD debug outputs.

---
 rtl/seg_grade_decoder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seg_grade_decoder.sv
// seg_grade_decoder: receive side of the grade-letter 7-segment path.
// Watches the segment bus and accepts a pattern once it has been held
// for STABLE_CYCLES edges. It then decodes the pattern to a letter code,
// pulses letter_valid for one cycle, and keeps saturating tallies.
module seg_grade_decoder #(
    parameter int NBITS_SEG     = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int NBITS_CNT     = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic [NBITS_SEG-1:0] seg_in,
    input  logic                 clear,
    output logic                 letter_valid,
    output logic [1:0]           letter_code,
    output logic [NBITS_CNT-1:0] cnt_a,
    output logic [NBITS_CNT-1:0] cnt_f,
    output logic [NBITS_CNT-1:0] cnt_p,
    output logic [NBITS_CNT-1:0] err_cnt,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETTLING = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    localparam logic [NBITS_SEG-1:0] PAT_A = NBITS_SEG'(8'b0111_0111);
    localparam logic [NBITS_SEG-1:0] PAT_F = NBITS_SEG'(8'b0111_0001);
    localparam logic [NBITS_SEG-1:0] PAT_P = NBITS_SEG'(8'b0111_0011);

    localparam logic [7:0]           STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [NBITS_CNT-1:0] CNT_MAX   = {NBITS_CNT{1'b1}};

    logic [1:0]           state_q, state_d;
    logic [7:0]           stab_q, stab_d;
    logic [NBITS_SEG-1:0] seg_q;
    logic                 valid_q;
    logic [1:0]           code_q, code_d;
    logic                 busy_q;
    logic                 lock;
    logic [1:0]           dec;
    logic [NBITS_CNT-1:0] tally_w [4];

    // Decode the registered pattern; on a lock edge it equals seg_in.
    always_comb begin
        dec = 2'd0;
        if (seg_q == PAT_A)      dec = 2'd1;
        else if (seg_q == PAT_F) dec = 2'd2;
        else if (seg_q == PAT_P) dec = 2'd3;
    end

    // Settle/lock sequencing; any change restarts the stability count.
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        lock    = 1'b0;
        if (seg_in != seg_q) begin
            stab_d  = 8'd0;
            state_d = (seg_in == '0) ? ST_IDLE : ST_SETTLING;
        end else if (state_q == ST_SETTLING) begin
            if (stab_q == STAB_LAST) begin
                state_d = ST_LOCKED;
                lock    = 1'b1;
            end else begin
                stab_d = stab_q + 8'd1;
            end
        end
        code_d = lock ? dec : code_q;
    end

    // Core state, input register and event outputs.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            stab_q  <= 8'd0;
            seg_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            seg_q   <= seg_in;
            valid_q <= lock;
            code_q  <= code_d;
            busy_q  <= (state_d == ST_SETTLING);
        end
    end

    // One saturating tally per decode result; index 0 counts unknown patterns.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_tally
            logic [NBITS_CNT-1:0] cnt_q, cnt_d;
            logic                 hit;

            assign hit = lock && (dec == 2'(gi));

            // Clear takes priority over a coincident increment.
            always_comb begin
                cnt_d = cnt_q;
                if (clear)                          cnt_d = '0;
                else if (hit && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
            end

            // Tally register.
            always_ff @(posedge clk_2 or posedge reset) begin
                if (reset) cnt_q <= '0;
                else       cnt_q <= cnt_d;
            end

            assign tally_w[gi] = cnt_q;
        end
    endgenerate

    assign letter_valid = valid_q;
    assign letter_code  = code_q;
    assign busy         = busy_q;
    assign err_cnt      = tally_w[0];
    assign cnt_a        = tally_w[1];
    assign cnt_f        = tally_w[2];
    assign cnt_p        = tally_w[3];

endmodule
